// File: rtl/dmem_responder.sv
// Fixed-latency data-memory responder: accepts one load or store at a time, answers
// exactly LATENCY cycles later with a one-cycle done pulse, and keeps a sticky error flag.
package dmem_pkg;
  typedef logic [31:0] word32_t;
endpackage

module dmem_responder
  import dmem_pkg::*;
#(
  parameter int DEPTH_WORDS = 1024,
  parameter int LATENCY     = 2
) (
  input  logic    clk_i,
  input  logic    reset_i,
  input  logic    dmem_read_i,
  input  logic    dmem_write_i,
  input  word32_t dmem_addr_i,
  input  word32_t dmem_data_i,
  output word32_t dmem_rd_data_o,
  output logic    dmem_done_o,
  output logic    dmem_err_o
);

  localparam int          AW         = $clog2(DEPTH_WORDS);
  localparam logic [3:0]  LAT_M1     = 4'(LATENCY - 1);
  localparam logic [63:0] ADDR_LIMIT = 64'(DEPTH_WORDS) * 64'd4;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUSY = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  function automatic logic addr_legal(input word32_t addr);
    return (addr[1:0] == 2'b00) && ({32'd0, addr} < ADDR_LIMIT);
  endfunction

  state_t          state_q, state_d;
  logic [3:0]      cnt_q, cnt_d;
  logic            is_store_q, is_store_d;
  logic [AW-1:0]   idx_q, idx_d;
  word32_t         wdata_q, wdata_d;
  logic            legal_q, legal_d;
  logic            done_q, done_d;
  word32_t         rd_data_q, rd_data_d;
  logic            err_q, err_d;

  logic [AW-1:0]   in_idx_s;
  logic            in_legal_s;
  logic [AW-1:0]   mem_idx_s;
  word32_t         mem_word_s;
  logic            mem_we_s;

  word32_t mem [DEPTH_WORDS];

  assign in_idx_s   = dmem_addr_i[2 +: AW];
  assign in_legal_s = addr_legal(dmem_addr_i);
  // The only read is in the acceptance cycle (LATENCY=1) or the last BUSY cycle, so one port suffices.
  assign mem_idx_s  = (state_q == ST_IDLE) ? in_idx_s : idx_q;
  assign mem_word_s = mem[mem_idx_s];
  assign mem_we_s   = (state_q == ST_DONE) && is_store_q && legal_q && !reset_i;

  // Array write port; contents deliberately survive reset.
  always_ff @(posedge clk_i) begin
    if (mem_we_s) begin
      mem[idx_q] <= wdata_q;
    end
  end

  // Next-state, latching and output decode for the request FSM.
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    is_store_d = is_store_q;
    idx_d      = idx_q;
    wdata_d    = wdata_q;
    legal_d    = legal_q;
    done_d     = 1'b0;
    rd_data_d  = 32'h0000_0000;
    err_d      = err_q;
    case (state_q)
      ST_IDLE: begin
        if (dmem_read_i ^ dmem_write_i) begin
          is_store_d = dmem_write_i;
          idx_d      = in_idx_s;
          wdata_d    = dmem_data_i;
          legal_d    = in_legal_s;
          if (LATENCY == 1) begin
            state_d   = ST_DONE;
            cnt_d     = 4'd0;
            done_d    = 1'b1;
            rd_data_d = (dmem_read_i && in_legal_s) ? mem_word_s : 32'h0000_0000;
            err_d     = err_q | ~in_legal_s;
          end else begin
            state_d = ST_BUSY;
            cnt_d   = LAT_M1;
          end
        end else if (dmem_read_i && dmem_write_i) begin
          err_d = 1'b1;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_BUSY: begin
        err_d = err_q | dmem_read_i | dmem_write_i;
        if (cnt_q <= 4'd1) begin
          state_d   = ST_DONE;
          cnt_d     = 4'd0;
          done_d    = 1'b1;
          rd_data_d = (!is_store_q && legal_q) ? mem_word_s : 32'h0000_0000;
          err_d     = err_q | dmem_read_i | dmem_write_i | ~legal_q;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      ST_DONE: begin
        state_d = ST_IDLE;
        err_d   = err_q | dmem_read_i | dmem_write_i;
      end
      default: begin
        state_d = ST_IDLE;
        cnt_d   = 4'd0;
      end
    endcase
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_q    <= ST_IDLE;
      cnt_q      <= 4'd0;
      is_store_q <= 1'b0;
      idx_q      <= '0;
      wdata_q    <= 32'h0000_0000;
      legal_q    <= 1'b0;
      done_q     <= 1'b0;
      rd_data_q  <= 32'h0000_0000;
      err_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      is_store_q <= is_store_d;
      idx_q      <= idx_d;
      wdata_q    <= wdata_d;
      legal_q    <= legal_d;
      done_q     <= done_d;
      rd_data_q  <= rd_data_d;
      err_q      <= err_d;
    end
  end

  assign dmem_rd_data_o = rd_data_q;
  assign dmem_done_o    = done_q;
  assign dmem_err_o     = err_q;

endmodule
